// File: rtl/comm_cmd_arbiter_if.sv
// comm_cmd_arbiter_if
//   Bundles the requester side and the CommMaster side of the command
//   arbiter into one interface.
//   slave  : arbiter view (takes requests and CommMaster flags, drives
//            completion, status and the CommMaster command).
//   master : environment view (requesters plus CommMaster).
interface comm_cmd_arbiter_if;
    logic [1:0]  req;           // per-requester request level
    logic [7:0]  cmd0;          // requester 0 command byte
    logic [15:0] data0;         // requester 0 data word
    logic [7:0]  cmd1;          // requester 1 command byte
    logic [15:0] data1;         // requester 1 data word
    logic [1:0]  done;          // one-hot completion pulse
    logic        err;           // 1 = timeout, valid with done
    logic [7:0]  resp_out;      // response byte, valid with done
    logic        busy;          // high whenever not idle
    logic        snd_cmd;       // one-cycle send pulse to CommMaster
    logic [7:0]  cmd_out;       // latched command to CommMaster
    logic [15:0] data_out;      // latched data to CommMaster
    logic        frm_snt;       // CommMaster frame transmitted
    logic        resp_rdy;      // CommMaster response ready
    logic [7:0]  resp;          // CommMaster response byte
    logic        clr_resp_rdy;  // knocks down resp_rdy

    modport slave (
        input  req, cmd0, data0, cmd1, data1, frm_snt, resp_rdy, resp,
        output done, err, resp_out, busy, snd_cmd, cmd_out, data_out, clr_resp_rdy
    );

    modport master (
        output req, cmd0, data0, cmd1, data1, frm_snt, resp_rdy, resp,
        input  done, err, resp_out, busy, snd_cmd, cmd_out, data_out, clr_resp_rdy
    );
endinterface

// File: rtl/comm_cmd_arbiter.sv
// comm_cmd_arbiter
//   Shares the CommMaster wireless command link between two requesters.
//   Round-robin arbitration, latches the winner's command/data, sequences
//   CommMaster through send / frame-sent / response with a timeout, and
//   returns the response (or a timeout error) to the granted requester.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : comm_cmd_arbiter_if.slave (requester and CommMaster signals)
// Parameters:
//   TMO_CYC : cycles from the snd_cmd cycle to the timeout done
//   TMO_W   : timer width, 2**TMO_W must exceed TMO_CYC
module comm_cmd_arbiter #(
    parameter int unsigned TMO_CYC = 150000,
    parameter int unsigned TMO_W   = 18
) (
    input  logic                clk,
    input  logic                rst,
    comm_cmd_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_SNT,
        WAIT_RESP,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               gnt_q, gnt_d;
    logic               last_gnt_q, last_gnt_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [15:0]        data_q, data_d;
    logic [7:0]         resp_q, resp_d;
    logic               err_q, err_d;
    logic [TMO_W-1:0]   timer_q, timer_d;

    logic               snd_c;
    logic               clr_c;
    logic [1:0]         done_c;
    logic               tmo;
    logic               pick;

    // The timer reads 0 during the SEND cycle, so it equals the number of
    // cycles elapsed since snd_cmd; the last wait cycle is TMO_CYC-1 and the
    // timeout done lands exactly TMO_CYC cycles after snd_cmd.
    assign tmo  = (timer_q == TMO_W'(TMO_CYC - 1));

    // Contention goes to whoever did not win last time.
    assign pick = (bus.req == 2'b11) ? ~last_gnt_q : bus.req[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            cmd_q      <= '0;
            data_q     <= '0;
            resp_q     <= '0;
            err_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            resp_q     <= resp_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        resp_d     = resp_q;
        err_d      = err_q;
        timer_d    = timer_q;
        snd_c      = 1'b0;
        clr_c      = 1'b0;
        done_c     = 2'b00;

        unique case (state_q)
            IDLE: begin
                // A stale response is flushed without blocking arbitration.
                clr_c = bus.resp_rdy;
                if (bus.req != 2'b00) begin
                    gnt_d      = pick;
                    last_gnt_d = pick;
                    cmd_d      = pick ? bus.cmd1  : bus.cmd0;
                    data_d     = pick ? bus.data1 : bus.data0;
                    timer_d    = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                snd_c   = 1'b1;
                timer_d = timer_q + TMO_W'(1);
                state_d = WAIT_SNT;
            end
            WAIT_SNT: begin
                timer_d = timer_q + TMO_W'(1);
                // resp_rdy arriving with frm_snt is held by CommMaster and
                // picked up in WAIT_RESP on the next cycle.
                if (bus.frm_snt) begin
                    state_d = WAIT_RESP;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            WAIT_RESP: begin
                timer_d = timer_q + TMO_W'(1);
                if (bus.resp_rdy) begin
                    resp_d  = bus.resp;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_c  = gnt_q ? 2'b10 : 2'b01;
                clr_c   = ~err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.done         = done_c;
    assign bus.err          = err_q;
    assign bus.resp_out     = resp_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.snd_cmd      = snd_c;
    assign bus.cmd_out      = cmd_q;
    assign bus.data_out     = data_q;
    assign bus.clr_resp_rdy = clr_c & ~rst;

endmodule

// File: tb/tb_comm_cmd_arbiter.sv
// tb_comm_cmd_arbiter
//   Directed-vector bench for comm_cmd_arbiter (TMO_CYC=100). Plays both
//   requesters and CommMaster; every expected value is hand-derived.
module tb_comm_cmd_arbiter;

    logic clk;
    logic rst;
    int   errs;
    int   checks;

    comm_cmd_arbiter_if bus ();

    comm_cmd_arbiter #(
        .TMO_CYC (100),
        .TMO_W   (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered in an IDLE cycle with the request already driven; returns in
    // the IDLE cycle after DONE. Expected command/data are the values the
    // bench itself drove for requester g at grant time.
    task automatic run_txn(input int g, input logic [7:0] rsp, input bit both_flags,
                           input bit mid_drop, input bit drop_all_at_done, input string tag);
        logic [7:0]  ecmd;
        logic [15:0] edata;
        logic [1:0]  eone;
        ecmd  = (g == 1) ? bus.cmd1  : bus.cmd0;
        edata = (g == 1) ? bus.data1 : bus.data0;
        eone  = (g == 1) ? 2'b10 : 2'b01;

        tick; // SEND
        checks++; if (bus.snd_cmd !== 1'b1) begin errs++; $display("FAIL %s snd_cmd got=%0b exp=1", tag, bus.snd_cmd); end
        checks++; if (bus.cmd_out !== ecmd) begin errs++; $display("FAIL %s cmd_out got=%h exp=%h", tag, bus.cmd_out, ecmd); end
        checks++; if (bus.data_out !== edata) begin errs++; $display("FAIL %s data_out got=%h exp=%h", tag, bus.data_out, edata); end
        checks++; if (bus.busy !== 1'b1 || bus.done !== 2'b00) begin errs++; $display("FAIL %s send_busy got busy=%0b done=%b exp busy=1 done=00", tag, bus.busy, bus.done); end

        tick; // WAIT_SNT
        checks++; if (bus.snd_cmd !== 1'b0) begin errs++; $display("FAIL %s snd_cmd_pulse got=%0b exp=0", tag, bus.snd_cmd); end
        if (mid_drop) begin
            bus.req[g] = 1'b0;
            if (g == 1) begin bus.cmd1 = ~ecmd; bus.data1 = ~edata; end
            else        begin bus.cmd0 = ~ecmd; bus.data0 = ~edata; end
        end
        bus.frm_snt = 1'b1;
        if (both_flags) begin bus.resp = rsp; bus.resp_rdy = 1'b1; end

        tick; // WAIT_RESP
        checks++; if (bus.done !== 2'b00) begin errs++; $display("FAIL %s early_done got=%b exp=00", tag, bus.done); end
        bus.frm_snt  = 1'b0;
        bus.resp     = rsp;
        bus.resp_rdy = 1'b1;

        tick; // DONE
        checks++; if (bus.done !== eone) begin errs++; $display("FAIL %s done got=%b exp=%b", tag, bus.done, eone); end
        checks++; if (bus.err !== 1'b0) begin errs++; $display("FAIL %s err got=%0b exp=0", tag, bus.err); end
        checks++; if (bus.resp_out !== rsp) begin errs++; $display("FAIL %s resp_out got=%h exp=%h", tag, bus.resp_out, rsp); end
        checks++; if (bus.clr_resp_rdy !== 1'b1) begin errs++; $display("FAIL %s clr_resp_rdy got=%0b exp=1", tag, bus.clr_resp_rdy); end
        checks++; if (bus.cmd_out !== ecmd) begin errs++; $display("FAIL %s cmd_hold got=%h exp=%h", tag, bus.cmd_out, ecmd); end
        bus.resp_rdy = 1'b0; // CommMaster honours clr_resp_rdy
        if (drop_all_at_done) bus.req = 2'b00;

        tick; // IDLE gap
        checks++; if (bus.done !== 2'b00 || bus.busy !== 1'b0 || bus.snd_cmd !== 1'b0)
            begin errs++; $display("FAIL %s idle_gap got done=%b busy=%0b snd=%0b exp 00/0/0", tag, bus.done, bus.busy, bus.snd_cmd); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 2'b00 || bus.snd_cmd !== 1'b0 || bus.clr_resp_rdy !== 1'b0)
            begin errs++; $display("FAIL reset_ctrl got busy=%0b done=%b snd=%0b clr=%0b exp all 0", bus.busy, bus.done, bus.snd_cmd, bus.clr_resp_rdy); end
        checks++; if (bus.cmd_out !== 8'h00 || bus.data_out !== 16'h0000 || bus.resp_out !== 8'h00 || bus.err !== 1'b0)
            begin errs++; $display("FAIL reset_data got cmd=%h data=%h resp=%h err=%0b exp 0", bus.cmd_out, bus.data_out, bus.resp_out, bus.err); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_battery_read;
        bus.cmd0  = 8'h01;
        bus.data0 = 16'h0000;
        bus.req   = 2'b01;
        run_txn(0, 8'hC0, 1'b0, 1'b0, 1'b1, "battery");
    endtask

    // Requester 0 drops req and changes cmd0/data0 mid-flight; frm_snt and
    // resp_rdy arrive together.
    task automatic test_drop_and_both_flags;
        bus.cmd0  = 8'h0A;
        bus.data0 = 16'hBEEF;
        bus.req   = 2'b01;
        run_txn(0, 8'h7E, 1'b1, 1'b1, 1'b1, "drop_both");
    endtask

    task automatic test_simultaneous;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.cmd0  = 8'h11; bus.data0 = 16'h1111;
        bus.cmd1  = 8'h22; bus.data1 = 16'h2222;
        bus.req   = 2'b11;
        run_txn(0, 8'hA1, 1'b0, 1'b0, 1'b0, "simul_r0");
        run_txn(1, 8'hA2, 1'b0, 1'b0, 1'b0, "simul_r1");
    endtask

    task automatic test_back_to_back;
        bus.cmd0 = 8'h31; bus.data0 = 16'h3131;
        bus.cmd1 = 8'h32; bus.data1 = 16'h3232;
        run_txn(0, 8'h41, 1'b0, 1'b0, 1'b0, "b2b_1");
        run_txn(1, 8'h42, 1'b0, 1'b0, 1'b0, "b2b_2");
        run_txn(0, 8'h43, 1'b0, 1'b0, 1'b0, "b2b_3");
        run_txn(1, 8'h44, 1'b0, 1'b0, 1'b1, "b2b_4");
    endtask

    task automatic test_timeout;
        int early;
        bus.cmd0 = 8'h05; bus.data0 = 16'h0505;
        bus.req  = 2'b01;
        tick; // SEND
        checks++; if (bus.snd_cmd !== 1'b1) begin errs++; $display("FAIL tmo_snd got=%0b exp=1", bus.snd_cmd); end
        tick; // snd_cmd + 1, WAIT_SNT
        bus.frm_snt = 1'b1;
        tick; // snd_cmd + 2, WAIT_RESP
        bus.frm_snt = 1'b0;
        early = 0;
        for (int k = 2; k < 100; k++) begin
            if (bus.done !== 2'b00 || bus.busy !== 1'b1) early++;
            tick;
        end
        checks++; if (early != 0) begin errs++; $display("FAIL tmo_early got=%0d bad cycles exp=0", early); end
        // snd_cmd + 100
        checks++; if (bus.done !== 2'b01) begin errs++; $display("FAIL tmo_done got=%b exp=01", bus.done); end
        checks++; if (bus.err !== 1'b1) begin errs++; $display("FAIL tmo_err got=%0b exp=1", bus.err); end
        checks++; if (bus.resp_out !== 8'h44) begin errs++; $display("FAIL tmo_resp_hold got=%h exp=44", bus.resp_out); end
        checks++; if (bus.clr_resp_rdy !== 1'b0) begin errs++; $display("FAIL tmo_clr got=%0b exp=0", bus.clr_resp_rdy); end
        bus.req = 2'b00;
        tick;
        checks++; if (bus.done !== 2'b00 || bus.err !== 1'b1 || bus.busy !== 1'b0)
            begin errs++; $display("FAIL tmo_after got done=%b err=%0b busy=%0b exp 00/1/0", bus.done, bus.err, bus.busy); end
    endtask

    task automatic test_reset_mid_txn;
        bus.cmd0 = 8'h66; bus.data0 = 16'h6666;
        bus.req  = 2'b01;
        tick; // SEND
        tick; // WAIT_SNT
        bus.frm_snt = 1'b1;
        tick; // WAIT_RESP
        bus.frm_snt = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 2'b00 || bus.snd_cmd !== 1'b0 || bus.clr_resp_rdy !== 1'b0 ||
                      bus.cmd_out !== 8'h00 || bus.data_out !== 16'h0000 || bus.resp_out !== 8'h00 || bus.err !== 1'b0)
            begin errs++; $display("FAIL rst_async got busy=%0b done=%b snd=%0b clr=%0b cmd=%h data=%h resp=%h err=%0b exp all 0",
                                   bus.busy, bus.done, bus.snd_cmd, bus.clr_resp_rdy, bus.cmd_out, bus.data_out, bus.resp_out, bus.err); end
        bus.req = 2'b00;
        tick;
        tick;
        checks++; if (bus.done !== 2'b00) begin errs++; $display("FAIL rst_no_done got=%b exp=00", bus.done); end
        rst = 1'b0;
        bus.cmd1 = 8'h33; bus.data1 = 16'h3333;
        bus.req  = 2'b10;
        run_txn(1, 8'h5A, 1'b0, 1'b0, 1'b1, "after_rst");
    endtask

    task automatic test_stale_resp;
        bus.req      = 2'b00;
        bus.resp     = 8'hEE;
        bus.resp_rdy = 1'b1;
        #1;
        checks++; if (bus.clr_resp_rdy !== 1'b1 || bus.done !== 2'b00 || bus.busy !== 1'b0)
            begin errs++; $display("FAIL stale_clr got clr=%0b done=%b busy=%0b exp 1/00/0", bus.clr_resp_rdy, bus.done, bus.busy); end
        tick;
        bus.resp_rdy = 1'b0;
        #1;
        checks++; if (bus.clr_resp_rdy !== 1'b0 || bus.done !== 2'b00 || bus.busy !== 1'b0 || bus.resp_out !== 8'h5A)
            begin errs++; $display("FAIL stale_after got clr=%0b done=%b busy=%0b resp=%h exp 0/00/0/5a", bus.clr_resp_rdy, bus.done, bus.busy, bus.resp_out); end
    endtask

    initial begin
        errs         = 0;
        checks       = 0;
        rst          = 1'b1;
        bus.req      = 2'b00;
        bus.cmd0     = 8'h00;
        bus.data0    = 16'h0000;
        bus.cmd1     = 8'h00;
        bus.data1    = 16'h0000;
        bus.frm_snt  = 1'b0;
        bus.resp_rdy = 1'b0;
        bus.resp     = 8'h00;

        test_reset;
        test_battery_read;
        test_drop_and_both_flags;
        test_simultaneous;
        test_back_to_back;
        test_timeout;
        test_reset_mid_txn;
        test_stale_resp;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
